// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory signals around the shared memory port.
// The arbiter takes the slave side; requesters and memory drive the master side.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_gnt;
  logic                 i_rvalid;
  logic [WORD_SIZE-1:0] i_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [WORD_SIZE-1:0] d_rdata;

  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_ready;
  logic                 mem_rvalid;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and data (D) requesters.
// Read responses are routed back in order through an owner-tag queue.
module mem_port_arbiter #(
  parameter int WORD_SIZE       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic Clock,
  input  logic Reset,
  mem_port_arbiter_if.slave bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic err
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [CW-1:0]              count;
  logic [SW-1:0]              starve_cnt;
  logic                       err_q;

  logic full;
  logic empty;
  logic i_ok;
  logic d_ok;
  logic force_i;
  logic d_wins;
  logic sel_i;
  logic sel_d;
  logic push;
  logic pop;
  logic head_tag;

  // Queue status and issue eligibility from registered occupancy
  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    i_ok    = bus.i_req & ~full;
    d_ok    = bus.d_req & (bus.d_we | ~full);
    force_i = bus.i_req & (starve_cnt >= STARVE_MAX);
    d_wins  = bus.d_req & ~force_i;
  end

  // Pick the issuing requester; fall back to the other if the winner is blocked
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (!Reset) begin
      if (d_wins) begin
        if (d_ok)      sel_d = 1'b1;
        else if (i_ok) sel_i = 1'b1;
      end else begin
        if (i_ok)      sel_i = 1'b1;
        else if (d_ok) sel_d = 1'b1;
      end
    end
  end

  // Drive memory request fields and grants from the selection
  always_comb begin
    bus.mem_req   = sel_i | sel_d;
    bus.mem_we    = sel_d & bus.d_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (sel_d) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (sel_i) begin
      bus.mem_addr  = bus.i_addr;
    end
    bus.i_gnt = sel_i & bus.mem_ready;
    bus.d_gnt = sel_d & bus.mem_ready;
  end

  // Route read responses to the owner at the head of the tag queue
  always_comb begin
    push         = bus.i_gnt | (bus.d_gnt & ~bus.d_we);
    pop          = bus.mem_rvalid & ~empty & ~Reset;
    head_tag     = tag_q[rd_ptr];
    bus.i_rvalid = pop & ~head_tag;
    bus.d_rvalid = pop & head_tag;
    bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
    outstanding  = count;
    err          = err_q;
  end

  // Owner-tag FIFO: push on granted read, pop on response
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tag_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= sel_d;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Count consecutive denied fetch cycles, saturating at the limit
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (!bus.i_req || bus.i_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Sticky flag for a response arriving with no read in flight
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (bus.mem_rvalid && empty) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency memory model.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
module tb_mem_port_arbiter;

  logic       Clock;
  logic       Reset;
  logic [2:0] outstanding;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  bit          auto_en = 0;
  int          lat = 1;
  logic [7:0]  pv = '0;
  logic [15:0] pd [8];

  mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

  mem_port_arbiter #(
    .WORD_SIZE(16),
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT(3)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus),
    .outstanding(outstanding),
    .err(err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the auto memory answers reads after lat cycles
  task automatic tick();
    bit          iss;
    logic [15:0] a;
    iss = auto_en && bus.mem_req && bus.mem_ready && !bus.mem_we;
    a   = bus.mem_addr;
    @(posedge Clock);
    #1;
    for (int k = 0; k < 7; k++) begin
      pv[k] = pv[k+1];
      pd[k] = pd[k+1];
    end
    pv[7] = 1'b0;
    if (iss) begin
      pv[lat-1] = 1'b1;
      pd[lat-1] = a ^ 16'hA5A5;
    end
    if (auto_en) begin
      bus.mem_rvalid = pv[0];
      bus.mem_rdata  = pv[0] ? pd[0] : 16'h0;
    end
  endtask

  // Single manual response pulse, checking which requester receives it
  task automatic resp(input string nm, input logic [15:0] data,
                      input bit to_d);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    #4;
    check({nm, "_i_rvalid"}, bus.i_rvalid, !to_d);
    check({nm, "_d_rvalid"}, bus.d_rvalid, to_d);
    check({nm, "_i_rdata"}, bus.i_rdata, to_d ? 16'h0 : data);
    check({nm, "_d_rdata"}, bus.d_rdata, to_d ? data : 16'h0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) pd[k] = 16'h0;
    Reset          = 1'b1;
    bus.i_req      = 1'b1;
    bus.i_addr     = 16'h0010;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = 16'h0;
    bus.d_wdata    = 16'h0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h9999;

    repeat (2) @(posedge Clock);
    #4;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_i_gnt", bus.i_gnt, 0);
    check("rst_i_rvalid", bus.i_rvalid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);

    // single fetch, latency 2
    @(posedge Clock);
    #1;
    Reset          = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    auto_en        = 1;
    lat            = 2;
    #4;
    check("t1_i_gnt", bus.i_gnt, 1);
    check("t1_mem_addr", bus.mem_addr, 16'h0010);
    check("t1_d_gnt", bus.d_gnt, 0);
    check("t1_out0", outstanding, 0);
    tick();
    bus.i_req = 1'b0;
    #4;
    check("t1_out1", outstanding, 1);
    check("t1_no_rvalid", bus.i_rvalid, 0);
    tick();
    #4;
    check("t1_i_rvalid", bus.i_rvalid, 1);
    check("t1_i_rdata", bus.i_rdata, 16'hA5B5);
    check("t1_d_rvalid", bus.d_rvalid, 0);
    tick();
    #4;
    check("t1_out_end", outstanding, 0);
    tick();

    // both requesting: D,D,D,I repeating
    lat        = 1;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0100;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0200;
    for (int k = 0; k < 8; k++) begin
      #4;
      check($sformatf("t2_i_gnt%0d", k), bus.i_gnt, (k % 4) == 3);
      check($sformatf("t2_d_gnt%0d", k), bus.d_gnt, (k % 4) != 3);
      if (k == 1) begin
        check("t2_d_rvalid", bus.d_rvalid, 1);
        check("t2_d_rdata", bus.d_rdata, 16'hA7A5);
      end
      if (k == 4) begin
        check("t2_i_rvalid", bus.i_rvalid, 1);
        check("t2_i_rdata", bus.i_rdata, 16'hA4A5);
        check("t2_d_quiet", bus.d_rvalid, 0);
      end
      tick();
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    #4;
    check("t2_last_i", bus.i_rvalid, 1);
    check("t2_out1", outstanding, 1);
    tick();
    #4;
    check("t2_out0", outstanding, 0);
    auto_en        = 0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    tick();

    // fill queue with D reads, then write while full
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0300;
    for (int k = 0; k < 4; k++) begin
      #4;
      check($sformatf("t3_fill%0d", k), bus.d_gnt, 1);
      tick();
    end
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0040;
    bus.d_wdata = 16'hBEEF;
    bus.i_req   = 1'b1;
    bus.i_addr  = 16'h0030;
    #4;
    check("t3_full", outstanding, 4);
    check("t3_wr_gnt", bus.d_gnt, 1);
    check("t3_mem_we", bus.mem_we, 1);
    check("t3_wdata", bus.mem_wdata, 16'hBEEF);
    check("t3_waddr", bus.mem_addr, 16'h0040);
    check("t3_i_held", bus.i_gnt, 0);
    tick();
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_wdata = 16'h0;
    #4;
    check("t3_still4", outstanding, 4);
    check("t3_i_held2", bus.i_gnt, 0);
    check("t3_no_req", bus.mem_req, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h1234;
    #4;
    check("t3_pop_d", bus.d_rvalid, 1);
    check("t3_pop_data", bus.d_rdata, 16'h1234);
    check("t3_i_held3", bus.i_gnt, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    #4;
    check("t3_out3", outstanding, 3);
    check("t3_i_gnt", bus.i_gnt, 1);
    tick();

    // full + pop + new D read: D waits one cycle
    bus.i_req      = 1'b0;
    bus.d_req      = 1'b1;
    bus.d_addr     = 16'h0050;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h5555;
    #4;
    check("t6_full", outstanding, 4);
    check("t6_d_rvalid", bus.d_rvalid, 1);
    check("t6_d_rdata", bus.d_rdata, 16'h5555);
    check("t6_d_held", bus.d_gnt, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    #4;
    check("t6_out3", outstanding, 3);
    check("t6_d_gnt", bus.d_gnt, 1);
    tick();
    bus.d_req = 1'b0;
    #4;
    check("t6_out4", outstanding, 4);
    tick();
    resp("t6_r0", 16'hA001, 1);
    resp("t6_r1", 16'hA002, 1);
    resp("t6_r2", 16'hA003, 0);
    resp("t6_r3", 16'hA004, 1);
    #4;
    check("t6_drained", outstanding, 0);
    tick();

    // interleaved I,D,I reads and in-order routing
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0011;
    #4;
    check("t4_g0", bus.i_gnt, 1);
    tick();
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0022;
    #4;
    check("t4_g1", bus.d_gnt, 1);
    tick();
    bus.d_req  = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0033;
    #4;
    check("t4_g2", bus.i_gnt, 1);
    tick();
    bus.i_req = 1'b0;
    #4;
    check("t4_out3", outstanding, 3);
    tick();
    resp("t4_r0", 16'h1111, 0);
    resp("t4_r1", 16'h2222, 1);
    resp("t4_r2", 16'h3333, 0);

    // stray response sets sticky err
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h7777;
    #4;
    check("t5_empty", outstanding, 0);
    check("t5_no_i", bus.i_rvalid, 0);
    check("t5_no_d", bus.d_rvalid, 0);
    check("t5_err_pre", err, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    #4;
    check("t5_err1", err, 1);
    tick();
    #4;
    check("t5_err_hold", err, 1);
    tick();

    // two reads in flight, then async reset mid-cycle
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0060;
    #4;
    tick();
    #4;
    tick();
    bus.i_req = 1'b0;
    #4;
    check("t5_out2", outstanding, 2);
    tick();
    bus.i_req      = 1'b1;
    bus.d_req      = 1'b1;
    bus.d_we       = 1'b0;
    bus.d_addr     = 16'h0070;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h4444;
    #2;
    Reset = 1'b1;
    #1;
    check("t5_rst_out", outstanding, 0);
    check("t5_rst_err", err, 0);
    check("t5_rst_req", bus.mem_req, 0);
    check("t5_rst_i_gnt", bus.i_gnt, 0);
    check("t5_rst_d_gnt", bus.d_gnt, 0);
    check("t5_rst_i_rv", bus.i_rvalid, 0);
    check("t5_rst_d_rv", bus.d_rvalid, 0);
    check("t5_rst_addr", bus.mem_addr, 0);
    @(posedge Clock);
    #1;
    Reset          = 1'b0;
    bus.i_req      = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    #4;
    check("t5_post_err", err, 0);
    check("t5_post_d_gnt", bus.d_gnt, 1);
    check("t5_post_addr", bus.mem_addr, 16'h0070);
    tick();
    bus.d_req = 1'b0;
    #4;
    check("t5_post_out", outstanding, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the pipeline's instruction-fetch requester (I) and data requester (D, the Memory stages).
- Arbitrates requests and issues them to the memory.
- Tracks outstanding reads in an in-order owner-tag queue so each read response returns to the requester that issued it.
- Produces per-requester grant, response-valid and starvation/error status used by the pipeline stall logic.

Parameters:
- WORD_SIZE, 16, width of addresses and data words.
- MAX_OUTSTANDING, 4, depth of the owner-tag queue (max reads in flight); power of two, ≥2.
- STARVE_LIMIT, 3, number of consecutive cycles I may be denied while requesting before it is forced to win.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- i_req  in  1  instruction fetch request (read only).
- i_addr  in  WORD_SIZE  fetch address.
- i_gnt  out  1  I request accepted this cycle.
- i_rvalid  out  1  I read data valid.
- i_rdata  out  WORD_SIZE  I read data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  write data.
- d_gnt  out  1  D request accepted this cycle.
- d_rvalid  out  1  D read data valid.
- d_rdata  out  WORD_SIZE  D read data.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  WORD_SIZE  memory address.
- mem_wdata  out  WORD_SIZE  memory write data.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  memory read response valid (in order, latency ≥1 cycle).
- mem_rdata  in  WORD_SIZE  memory read data.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads currently in flight.
- err  out  1  sticky: mem_rvalid received with empty tag queue.

Behaviour:
Request/grant path (combinational from inputs and registered state):
- Winner selection: D wins when d_req=1, unless starve_cnt ≥ STARVE_LIMIT and i_req=1, in which case I wins. I wins when it is the only requester.
- Issue gating: a read is blocked when the tag queue is full. A write is never blocked by the queue.
- If the winner is blocked and the other requester has an issuable request, the other requester is issued instead (no bubble).
- mem_req = 1 when a request is selected for issue. mem_we, mem_addr and mem_wdata come from the selected requester; mem_wdata = 0 and mem_we = 0 for I.
- Grant: the selected requester's gnt = mem_req & mem_ready. A requester holds req and its fields stable until gnt.
- When mem_req=0, mem_addr/mem_wdata/mem_we = 0.

Tag queue (FIFO of 1-bit owner tags, 0 = I, 1 = D):
- Push on a granted read; pop on mem_rvalid.
- Head tag routes mem_rdata to i_rdata/d_rdata and asserts i_rvalid or d_rvalid in the same cycle. The non-addressed rdata output is 0.
- Push and pop in the same cycle are both performed: occupancy unchanged, including when the queue is full. A read may still not be granted while full, because the full check uses registered occupancy.
- outstanding = registered occupancy.
- mem_rvalid with the queue empty: no rvalid asserted, err set to 1 on the next edge and held until Reset.

Starvation counter (starve_cnt, saturating at STARVE_LIMIT):
- Increments on each edge where i_req=1 and i_gnt=0.
- Clears to 0 on i_gnt or when i_req=0.

Reset (asynchronous, takes effect immediately):
- Queue emptied, starve_cnt=0, err=0, outstanding=0.
- While Reset=1: mem_req, i_gnt, d_gnt, i_rvalid, d_rvalid = 0; all data/address outputs = 0.
- In-flight reads are abandoned. A mem_rvalid arriving after reset deasserts sets err, so memory must be reset alongside this block.

Latency:
- Grant is zero-cycle (same cycle as req when mem_ready=1).
- Response latency is that of the memory plus 0 cycles.

Test Plan:
- Only I reads 0x0010, mem_ready=1, memory latency 2 → i_gnt in cycle 0, i_rvalid with rdata=mem[0x0010] in cycle 2, outstanding 1 then 0, d_* idle.
- I and D both request continuously (D reads), STARVE_LIMIT=3 → D granted cycles 0–2, I granted cycle 3, starve_cnt back to 0, pattern repeats every 4 cycles.
- D write 0xBEEF to 0x0040 while 4 reads outstanding (queue full) → D write granted, mem_we=1, outstanding stays 4; a concurrent I read is held (i_gnt=0) until a mem_rvalid pops.
- Interleaved grants I,D,I (reads) then three mem_rvalid pulses with data 0x1111, 0x2222, 0x3333 → i_rdata=0x1111, d_rdata=0x2222, i_rdata=0x3333 in order, no cross-routing.
- mem_rvalid with queue empty → no rvalid, err=1 next cycle and stays 1; pulse Reset mid-run with 2 reads outstanding → outstanding=0, err=0, all grants/valids 0 immediately.
- Full queue plus simultaneous mem_rvalid and new D read request → pop happens, D not granted that cycle, D granted the following cycle, outstanding returns to 4.
